// File: rtl/calc_input_seq_if.sv
// Operand-entry bus: switch/button inputs toward the sequencer and the
// captured operands plus load strobe back toward the calculator core.
interface calc_input_seq_if;
  logic [2:0] sw;
  logic       enter_btn;
  logic       clear_btn;
  logic [2:0] a;
  logic [2:0] b;
  logic [1:0] op;
  logic       load;
  logic [1:0] stage;

  modport master (
    output sw, enter_btn, clear_btn,
    input  a, b, op, load, stage
  );

  modport slave (
    input  sw, enter_btn, clear_btn,
    output a, b, op, load, stage
  );
endinterface

// File: rtl/calc_input_seq.sv
// Operand-entry sequencer: synchronises and debounces ENTER, synchronises
// CLEAR, and steps through A -> B -> OP captures, strobing load on the last.
module calc_input_seq #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input logic             clk,
  input logic             rst,
  calc_input_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_A  = 2'b00,
    S_B  = 2'b01,
    S_OP = 2'b10
  } state_t;

  logic             enter_meta;
  logic             enter_s;
  logic             clear_meta;
  logic             clear_s;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;
  logic             enter_pulse;

  state_t           state;
  logic [2:0]       a_q;
  logic [2:0]       b_q;
  logic [1:0]       op_q;
  logic             load_q;

  // Two-flop synchronisers for both raw buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enter_meta <= 1'b0;
      enter_s    <= 1'b0;
      clear_meta <= 1'b0;
      clear_s    <= 1'b0;
    end else begin
      enter_meta <= bus.enter_btn;
      enter_s    <= enter_meta;
      clear_meta <= bus.clear_btn;
      clear_s    <= clear_meta;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
  // samples that disagree with the current stable value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (enter_s == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable <= enter_s;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Delayed stable value for rising-edge (press) detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stable_q <= 1'b0;
    else     stable_q <= stable;
  end

  assign enter_pulse = stable & ~stable_q;

  // Entry FSM: capture one field per press; clear forces back to S_A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_A;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      load_q <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (clear_s) begin
        state <= S_A;
      end else if (enter_pulse) begin
        case (state)
          S_A: begin
            a_q   <= bus.sw;
            state <= S_B;
          end
          S_B: begin
            b_q   <= bus.sw;
            state <= S_OP;
          end
          S_OP: begin
            op_q   <= bus.sw[1:0];
            load_q <= 1'b1;
            state  <= S_A;
          end
          default: state <= S_A;
        endcase
      end
    end
  end

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign bus.op    = op_q;
  assign bus.load  = load_q;
  assign bus.stage = state;

endmodule

// File: tb/tb_calc_input_seq.sv
// Bench for calc_input_seq: directed press sequences with a behavioural
// model compared every cycle plus hand-computed literal expectations.
module tb_calc_input_seq;

  localparam int D = 4;

  logic clk;
  logic rst;

  calc_input_seq_if bus ();

  calc_input_seq #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs as seen by the DUT at each rising edge.
  logic       smp_enter = 1'b0;
  logic       smp_clear = 1'b0;
  logic [2:0] smp_sw    = '0;
  logic       smp_rst   = 1'b1;
  int         cyc       = 0;

  always @(posedge clk) begin
    smp_enter <= bus.enter_btn;
    smp_clear <= bus.clear_btn;
    smp_sw    <= bus.sw;
    smp_rst   <= rst;
    cyc       <= cyc + 1;
  end

  // Behavioural model: raw buttons delayed two edges, stable level flips
  // once the last D synchronised samples all disagree with it, press = rise.
  logic [2:0] m_a, m_b;
  logic [1:0] m_op, m_stage;
  logic       m_load;
  logic       m_es1, m_es, m_cs1, m_cs, m_stable, m_stable_q;
  bit         hist[$];
  int         load_total    = 0;
  int         last_load_cyc = -1;

  always @(negedge clk) begin
    logic pulse;
    bit   all_diff;
    if (rst || smp_rst) begin
      m_a = '0; m_b = '0; m_op = '0; m_stage = '0; m_load = 1'b0;
      m_es1 = 1'b0; m_es = 1'b0; m_cs1 = 1'b0; m_cs = 1'b0;
      m_stable = 1'b0; m_stable_q = 1'b0;
      hist.delete();
    end else begin
      pulse  = m_stable && !m_stable_q;
      m_load = 1'b0;
      if (m_cs) begin
        m_stage = 2'd0;
      end else if (pulse) begin
        if (m_stage == 2'd0) begin
          m_a = smp_sw; m_stage = 2'd1;
        end else if (m_stage == 2'd1) begin
          m_b = smp_sw; m_stage = 2'd2;
        end else begin
          m_op = smp_sw[1:0]; m_load = 1'b1; m_stage = 2'd0;
        end
      end
      m_stable_q = m_stable;
      hist.push_back(m_es);
      if (hist.size() > D) void'(hist.pop_front());
      if (hist.size() == D) begin
        all_diff = 1'b1;
        for (int i = 0; i < D; i++) if (hist[i] == m_stable) all_diff = 1'b0;
        if (all_diff) m_stable = !m_stable;
      end
      m_es  = m_es1;
      m_es1 = smp_enter;
      m_cs  = m_cs1;
      m_cs1 = smp_clear;
    end
    chk("a",     int'(bus.a),     int'(m_a));
    chk("b",     int'(bus.b),     int'(m_b));
    chk("op",    int'(bus.op),    int'(m_op));
    chk("load",  int'(bus.load),  int'(m_load));
    chk("stage", int'(bus.stage), int'(m_stage));
    if (bus.load) begin
      load_total++;
      last_load_cyc = cyc;
    end
  end

  task automatic press(input logic [2:0] v, input int hold, output int start);
    @(negedge clk);
    start = cyc;
    bus.sw = v;
    bus.enter_btn = 1'b1;
    repeat (hold) @(negedge clk);
    bus.enter_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int  st;
    int  lc0;
    bit  got;
    rst = 1'b1;
    bus.sw = '0;
    bus.enter_btn = 1'b0;
    bus.clear_btn = 1'b0;
    @(negedge clk);
    chk("reset_stage", int'(bus.stage), 0);
    chk("reset_load",  int'(bus.load),  0);
    chk("reset_a",     int'(bus.a),     0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: full entry and latency of load after the third press
    lc0 = load_total;
    press(3'b101, 10, st);
    chk("t1_stage_after_a", int'(bus.stage), 1);
    press(3'b011, 10, st);
    chk("t1_stage_after_b", int'(bus.stage), 2);
    press(3'b010, 10, st);
    chk("t1_stage_after_op", int'(bus.stage), 0);
    chk("t1_a", int'(bus.a), 5);
    chk("t1_b", int'(bus.b), 3);
    chk("t1_op", int'(bus.op), 2);
    chk("t1_load_count", load_total - lc0, 1);
    chk("t1_load_latency", last_load_cyc - st, 7);

    // 2: short pulse and bounce train are rejected
    lc0 = load_total;
    @(negedge clk);
    bus.sw = 3'b000;
    bus.enter_btn = 1'b1;
    repeat (3) @(negedge clk);
    bus.enter_btn = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.enter_btn = (i % 2 == 0);
      @(negedge clk);
    end
    bus.enter_btn = 1'b0;
    repeat (15) @(negedge clk);
    chk("t2_stage", int'(bus.stage), 0);
    chk("t2_a", int'(bus.a), 5);
    chk("t2_load_count", load_total - lc0, 0);

    // 3: long hold advances once; re-press advances again
    lc0 = load_total;
    bus.sw = 3'b111;
    bus.enter_btn = 1'b1;
    repeat (50) @(negedge clk);
    chk("t3_hold_stage", int'(bus.stage), 1);
    chk("t3_hold_a", int'(bus.a), 7);
    bus.enter_btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("t3_release_stage", int'(bus.stage), 1);
    press(3'b100, 10, st);
    chk("t3_repress_stage", int'(bus.stage), 2);
    chk("t3_b", int'(bus.b), 4);
    press(3'b001, 10, st);
    chk("t3_op", int'(bus.op), 1);
    chk("t3_load_count", load_total - lc0, 1);

    // 4: clear aborts after A and B, operands kept
    press(3'b110, 10, st);
    press(3'b001, 10, st);
    lc0 = load_total;
    bus.clear_btn = 1'b1;
    repeat (5) @(negedge clk);
    bus.clear_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_stage", int'(bus.stage), 0);
    chk("t4_a", int'(bus.a), 6);
    chk("t4_b", int'(bus.b), 1);
    chk("t4_load_count", load_total - lc0, 0);
    press(3'b010, 10, st);
    chk("t4_new_a", int'(bus.a), 2);
    chk("t4_new_stage", int'(bus.stage), 1);

    // 5: clear lands on the same edge as the S_OP press pulse
    press(3'b011, 10, st);
    chk("t5_pre_stage", int'(bus.stage), 2);
    lc0 = load_total;
    @(negedge clk);
    bus.sw = 3'b011;
    bus.enter_btn = 1'b1;
    repeat (4) @(negedge clk);
    bus.clear_btn = 1'b1;
    @(negedge clk);
    bus.clear_btn = 1'b0;
    repeat (5) @(negedge clk);
    bus.enter_btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_stage", int'(bus.stage), 0);
    chk("t5_op", int'(bus.op), 1);
    chk("t5_load_count", load_total - lc0, 0);

    // 6: asynchronous reset while load is high
    press(3'b001, 10, st);
    press(3'b010, 10, st);
    @(negedge clk);
    bus.sw = 3'b011;
    bus.enter_btn = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #2;
      if (bus.load) got = 1'b1;
    end
    chk("t6_load_seen", int'(got), 1);
    rst = 1'b1;
    bus.enter_btn = 1'b0;
    #1;
    chk("t6_async_load",  int'(bus.load),  0);
    chk("t6_async_a",     int'(bus.a),     0);
    chk("t6_async_b",     int'(bus.b),     0);
    chk("t6_async_op",    int'(bus.op),    0);
    chk("t6_async_stage", int'(bus.stage), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    press(3'b101, 10, st);
    chk("t6_after_a", int'(bus.a), 5);
    chk("t6_after_stage", int'(bus.stage), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
